// File: rtl/turfio_lmk_init_seq_if.sv
// Wishbone master-side bundle used by the LMK init sequencer (22-bit byte address, 32-bit data).
interface turfio_lmk_init_seq_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [21:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/turfio_lmk_init_seq.sv
// Startup sequencer: streams LMK words from a 1-cycle ROM into the genshift block over
// Wishbone, launching each shift and polling its status until the shifter goes idle.
module turfio_lmk_init_seq #(
    parameter int          N_WORDS    = 32,
    parameter int          ROM_AW     = 5,
    parameter logic [21:0] BASE       = 22'h001000,
    parameter logic [11:0] DATA_OFS   = 12'h004,
    parameter logic [11:0] CTRL_OFS   = 12'h000,
    parameter logic [31:0] CTRL_GO    = 32'h1,
    parameter int          BUSY_BIT   = 0,
    parameter int          POLL_LIMIT = 1023,
    parameter int          WB_TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          err_code_o,
    output logic [ROM_AW:0]     word_idx_o,
    output logic [ROM_AW-1:0]   rom_addr_o,
    input  logic [31:0]         rom_data_i,
    turfio_lmk_init_seq_if.master wb
);

    localparam int          IDX_W    = ROM_AW + 1;
    localparam int          WAIT_W   = $clog2(WB_TIMEOUT + 1);
    localparam int          POLL_W   = $clog2(POLL_LIMIT + 1);
    localparam logic [21:0] DATA_ADR = BASE + {10'd0, DATA_OFS};
    localparam logic [21:0] CTRL_ADR = BASE + {10'd0, CTRL_OFS};

    typedef enum logic [2:0] {
        IDLE, FETCH, WR_DATA, WR_GO, RD_STAT, NEXT, DONE, ERROR
    } state_e;

    state_e              state_q, state_d;
    logic                gap_q, gap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [31:0]         word_q, word_d;
    logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
    logic [POLL_W-1:0]   pollCnt_q, pollCnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          errCode_q, errCode_d;
    logic                busy;
    logic                access;
    logic                failReq;
    logic [1:0]          failCode;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gap_q     <= 1'b0;
            idx_q     <= '0;
            word_q    <= '0;
            waitCnt_q <= '0;
            pollCnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errCode_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            waitCnt_q <= waitCnt_d;
            pollCnt_q <= pollCnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            errCode_q <= errCode_d;
        end
    end

    // Bus strobes are decoded straight from state so a reset releases the bus without a clock.
    assign busy   = state_q inside {FETCH, WR_DATA, WR_GO, RD_STAT, NEXT};
    assign access = (state_q inside {WR_DATA, WR_GO, RD_STAT}) && !gap_q;

    assign wb.cyc_o = access;
    assign wb.stb_o = access;
    assign wb.we_o  = access && (state_q != RD_STAT);
    assign wb.sel_o = access ? 4'hF : 4'h0;
    assign wb.adr_o = !access ? 22'd0 : ((state_q == WR_DATA) ? DATA_ADR : CTRL_ADR);
    assign wb.dat_o = (access && state_q == WR_DATA) ? word_q :
                      (access && state_q == WR_GO)   ? CTRL_GO : 32'd0;

    assign busy_o     = busy;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = errCode_q;
    assign word_idx_o = idx_q;
    assign rom_addr_o = idx_q[ROM_AW-1:0];

    // gap_q doubles as the second-cycle marker in FETCH and the idle cycle between bus accesses.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        word_d    = word_q;
        waitCnt_d = '0;
        pollCnt_d = pollCnt_q;
        done_d    = done_q;
        err_d     = err_q;
        errCode_d = errCode_q;
        failReq   = 1'b0;
        failCode  = 2'd0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                state_d = IDLE;
                if (start_i) begin
                    state_d   = FETCH;
                    gap_d     = 1'b0;
                    idx_d     = '0;
                    pollCnt_d = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    errCode_d = 2'd0;
                end
            end
            FETCH: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else begin
                    word_d  = rom_data_i;
                    gap_d   = 1'b0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA, WR_GO, RD_STAT: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (wb.err_i) begin
                    failReq  = 1'b1;
                    failCode = 2'd1;
                end else if (wb.ack_i) begin
                    gap_d = 1'b1;
                    if (state_q == WR_DATA) begin
                        state_d = WR_GO;
                    end else if (state_q == WR_GO) begin
                        state_d = RD_STAT;
                    end else if (!wb.dat_i[BUSY_BIT]) begin
                        state_d = NEXT;
                        gap_d   = 1'b0;
                    end else if (pollCnt_q == POLL_W'(POLL_LIMIT - 1)) begin
                        failReq  = 1'b1;
                        failCode = 2'd3;
                    end else begin
                        pollCnt_d = pollCnt_q + POLL_W'(1);
                    end
                end else if (wb.rty_i) begin
                    gap_d = 1'b1;
                end else if (waitCnt_q == WAIT_W'(WB_TIMEOUT - 1)) begin
                    failReq  = 1'b1;
                    failCode = 2'd2;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            NEXT: begin
                idx_d     = idx_q + IDX_W'(1);
                pollCnt_d = '0;
                if (idx_q + IDX_W'(1) == IDX_W'(N_WORDS)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (failReq) begin
            state_d   = ERROR;
            gap_d     = 1'b0;
            err_d     = 1'b1;
            errCode_d = failCode;
        end

        // Abort wins over any response seen in the same cycle, including the NEXT increment.
        if (abort_i && busy) begin
            state_d   = ERROR;
            gap_d     = 1'b0;
            idx_d     = idx_q;
            pollCnt_d = pollCnt_q;
            done_d    = 1'b0;
            err_d     = 1'b1;
            errCode_d = 2'd0;
        end
    end

endmodule

// File: tb/tb_turfio_lmk_init_seq.sv
// Directed/randomized bench for turfio_lmk_init_seq: a cycle-stepped Wishbone slave model
// logs every access and each run is compared against a transaction list built from the table.
module tb_turfio_lmk_init_seq;

    localparam int          N          = 3;
    localparam logic [21:0] DATA_ADR   = 22'h001004;
    localparam logic [21:0] CTRL_ADR   = 22'h001000;

    typedef struct packed {
        logic        we;
        logic [21:0] adr;
        logic [31:0] dat;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, errO;
    logic [1:0]  errCode;
    logic [5:0]  wordIdx;
    logic [4:0]  romAddr;
    logic [31:0] romData;
    logic [31:0] rom [32];

    turfio_lmk_init_seq_if wb();

    turfio_lmk_init_seq #(.N_WORDS(N)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (errO),
        .err_code_o (errCode),
        .word_idx_o (wordIdx),
        .rom_addr_o (romAddr),
        .rom_data_i (romData),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) romData <= rom[romAddr];

    int   total = 0;
    int   bad = 0;
    acc_t log[$];
    acc_t expQ[$];
    logic pendStart = 1'b0;
    logic expectIdle = 1'b0;
    logic hang = 1'b0;
    logic stuckBusy = 1'b0;
    int   busyReads = 0;
    int   rtyLeft = 0;
    int   errGoAt = -1;
    int   abortWord = -1;
    int   midStartAt = 0;
    int   goCount, readsThisWord, statReads, cycHigh, runCycle, protoBad;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of slave behaviour: sample the master at the falling edge, answer for the next rise.
    task automatic applyStimulus();
        logic [31:0] rnd;
        logic        isRead, isData, isGo;
        @(negedge clk);
        start = pendStart;
        pendStart = 1'b0;
        abort = 1'b0;
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        wb.rty_i = 1'b0;
        wb.dat_i = 32'd0;
        if (expectIdle) begin
            checkOutput("cycAfterTerm", 32'(wb.cyc_o), 32'd0);
            expectIdle = 1'b0;
        end
        if (busy) begin
            runCycle++;
            if (runCycle == midStartAt) start = 1'b1;
        end
        if (wb.cyc_o) begin
            cycHigh++;
            if (wb.stb_o !== 1'b1 || wb.sel_o !== 4'hF) protoBad++;
            if (!hang) begin
                isRead = !wb.we_o;
                isData = wb.we_o && (wb.adr_o == DATA_ADR);
                isGo   = wb.we_o && (wb.adr_o == CTRL_ADR);
                log.push_back('{wb.we_o, wb.adr_o, isRead ? 32'd0 : wb.dat_o});
                if (isData && rtyLeft > 0) begin
                    wb.rty_i = 1'b1;
                    rtyLeft--;
                end else if (isGo && goCount == errGoAt) begin
                    wb.err_i = 1'b1;
                    expectIdle = 1'b1;
                    goCount++;
                end else begin
                    wb.ack_i = 1'b1;
                    if (isGo) begin
                        goCount++;
                        readsThisWord = 0;
                    end
                    if (isRead) begin
                        rnd = $urandom;
                        rnd[0] = stuckBusy || (readsThisWord < busyReads);
                        wb.dat_i = rnd;
                        if (abortWord >= 0 && goCount == abortWord + 1 && readsThisWord == 0) begin
                            abort = 1'b1;
                            expectIdle = 1'b1;
                        end
                        readsThisWord++;
                        statReads++;
                    end
                end
            end
        end
    endtask

    task automatic runSequence(input int budget);
        int n;
        log.delete();
        statReads = 0;
        readsThisWord = 0;
        goCount = 0;
        cycHigh = 0;
        runCycle = 0;
        protoBad = 0;
        expectIdle = 1'b0;
        pendStart = 1'b1;
        applyStimulus();
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (busy && n < budget);
        checkOutput("runFinished", 32'(busy), 32'd0);
        checkOutput("protocol", 32'(protoBad), 32'd0);
    endtask

    // Expected access list for a clean run: data, go, then (busy + 1) status reads per word.
    task automatic buildExpected(input int nBusy, input int nRty);
        expQ.delete();
        for (int w = 0; w < N; w++) begin
            for (int r = 0; r < ((w == 0) ? nRty : 0); r++) expQ.push_back('{1'b1, DATA_ADR, rom[w]});
            expQ.push_back('{1'b1, DATA_ADR, rom[w]});
            expQ.push_back('{1'b1, CTRL_ADR, 32'h1});
            for (int r = 0; r <= nBusy; r++) expQ.push_back('{1'b0, CTRL_ADR, 32'd0});
        end
    endtask

    task automatic compareLog();
        checkOutput("logLen", 32'(log.size()), 32'(expQ.size()));
        for (int i = 0; i < log.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("acc%0d.adr", i), {9'd0, log[i].we, log[i].adr}, {9'd0, expQ[i].we, expQ[i].adr});
            checkOutput($sformatf("acc%0d.dat", i), log[i].dat, expQ[i].dat);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".err"}, 32'(errO), 32'd0);
        checkOutput({tag, ".code"}, 32'(errCode), 32'd0);
        checkOutput({tag, ".idx"}, 32'(wordIdx), 32'd0);
        checkOutput({tag, ".cyc"}, 32'(wb.cyc_o), 32'd0);
        checkOutput({tag, ".stb"}, 32'(wb.stb_o), 32'd0);
        checkOutput({tag, ".romAddr"}, 32'(romAddr), 32'd0);
    endtask

    task automatic checkResult(input string tag, input logic d, input logic e, input logic [1:0] c, input int idx);
        checkOutput({tag, ".done"}, 32'(done), 32'(d));
        checkOutput({tag, ".err"}, 32'(errO), 32'(e));
        checkOutput({tag, ".code"}, 32'(errCode), 32'(c));
        checkOutput({tag, ".idx"}, 32'(wordIdx), 32'(idx));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        wb.ack_i = 1'b0;
        wb.err_i = 1'b0;
        wb.rty_i = 1'b0;
        wb.dat_i = 32'd0;

        repeat (2) @(negedge clk);
        checkIdleOutputs("inReset");
        rst = 1'b0;
        applyStimulus();
        checkIdleOutputs("afterReset");

        $display("[TB] clean run, two busy polls per word, stray start mid-run");
        busyReads = 2;
        midStartAt = $urandom_range(3, 12);
        runSequence(2000);
        midStartAt = 0;
        buildExpected(2, 0);
        compareLog();
        checkOutput("statReads", 32'(statReads), 32'd9);
        checkResult("clean", 1'b1, 1'b0, 2'd0, N);
        applyStimulus();
        checkOutput("doneHeld", 32'(done), 32'd1);

        $display("[TB] retry twice on first data write");
        busyReads = $urandom_range(0, 3);
        rtyLeft = 2;
        runSequence(2000);
        buildExpected(busyReads, 2);
        compareLog();
        checkResult("retry", 1'b1, 1'b0, 2'd0, N);

        $display("[TB] bus error on second go write");
        busyReads = 0;
        errGoAt = 1;
        runSequence(2000);
        errGoAt = -1;
        checkOutput("errLogLen", 32'(log.size()), 32'd5);
        checkResult("busErr", 1'b0, 1'b1, 2'd1, 1);

        $display("[TB] slave never answers");
        hang = 1'b1;
        runSequence(2000);
        hang = 1'b0;
        checkOutput("hangCycles", 32'(cycHigh), 32'd255);
        checkResult("busTimeout", 1'b0, 1'b1, 2'd2, 0);

        $display("[TB] status stuck busy");
        stuckBusy = 1'b1;
        runSequence(8000);
        stuckBusy = 1'b0;
        checkOutput("pollReads", 32'(statReads), 32'd1023);
        checkResult("pollTimeout", 1'b0, 1'b1, 2'd3, 0);

        $display("[TB] abort coincident with status ack");
        busyReads = 0;
        abortWord = 1;
        runSequence(2000);
        abortWord = -1;
        checkOutput("abortLogLen", 32'(log.size()), 32'd6);
        checkResult("abort", 1'b0, 1'b1, 2'd0, 1);

        $display("[TB] reset pulse during data write");
        hang = 1'b1;
        log.delete();
        pendStart = 1'b1;
        applyStimulus();
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!wb.cyc_o && n < 20);
        checkOutput("cycBeforeReset", 32'(wb.cyc_o), 32'd1);
        #2 rst = 1'b1;
        #1 checkIdleOutputs("midReset");
        @(negedge clk);
        rst = 1'b0;
        hang = 1'b0;
        busyReads = 1;
        runSequence(2000);
        buildExpected(1, 0);
        compareLog();
        checkResult("restart", 1'b1, 1'b0, 2'd0, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
